// File: rtl/apb_ic_pkg.sv
// Shared types and constants for the 1-master / N-slave APB fabric.
// Holds FSM encoding, error codes and the default 4-slave address map.
package apb_ic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_DECODE  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_SLVERR  = 2'b11;

  localparam int unsigned DEF_NUM_SLAVES = 4;

  localparam logic [127:0] DEF_SLV_BASE =
    {32'h3000, 32'h2000, 32'h1000, 32'h0000};

  localparam logic [127:0] DEF_SLV_MASK =
    {4{32'hFFFF_F000}};

endpackage

// File: rtl/apb_ic_decoder.sv
// Combinational base/mask priority decoder; lowest matching index wins.
// Ports: addr in; idx = winning slave, miss = no window matched.
module apb_ic_decoder
  import apb_ic_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = DEF_NUM_SLAVES,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned IDX_W      = 2,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE = DEF_SLV_BASE,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK = DEF_SLV_MASK
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [IDX_W-1:0]  idx,
  output logic              miss
);

  // Scan high to low so the lowest matching index is the last written.
  always_comb begin
    idx  = '0;
    miss = 1'b1;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((addr & SLV_MASK[i*ADDR_W +: ADDR_W]) ==
          SLV_BASE[i*ADDR_W +: ADDR_W]) begin
        idx  = IDX_W'(i);
        miss = 1'b0;
      end
    end
  end

endmodule

// File: rtl/apb_interconnect_nslv.sv
// 1-master / N-slave APB fabric: default slave, ready timeout, sticky error record.
// Master APB in, per-slave PSEL_S/PENABLE_S out, err_* record. Macro: APB_IC_TIMEOUT_EN.
module apb_interconnect_nslv
  import apb_ic_pkg::*;
#(
  parameter int unsigned NUM_SLAVES     = DEF_NUM_SLAVES,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE = DEF_SLV_BASE,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK = DEF_SLV_MASK,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                         PCLK,
  input  logic                         PRESET,
  input  logic                         PSEL,
  input  logic                         PENABLE,
  input  logic                         PWRITE,
  input  logic [ADDR_W-1:0]            PADDR,
  input  logic [DATA_W-1:0]            PWDATA,
  output logic [DATA_W-1:0]            PRDATA,
  output logic                         PREADY,
  output logic                         PSLVERR,
  output logic [NUM_SLAVES-1:0]        PSEL_S,
  output logic [NUM_SLAVES-1:0]        PENABLE_S,
  output logic                         PWRITE_S,
  output logic [ADDR_W-1:0]            PADDR_S,
  output logic [DATA_W-1:0]            PWDATA_S,
  input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA_S,
  input  logic [NUM_SLAVES-1:0]        PREADY_S,
  input  logic [NUM_SLAVES-1:0]        PSLVERR_S,
  input  logic                         err_clr,
  output logic                         err_valid,
  output logic [1:0]                   err_code,
  output logic [ADDR_W-1:0]            err_addr
);

  localparam int unsigned IDX_W =
    (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  sel_q, sel_d, dec_idx, cur_idx;
  logic              def_q, def_d, dec_miss, cur_def;
  logic              err_valid_q, err_valid_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;

  logic setup, access, slv_rdy, abort;
  logic pready_m, pslverr_m, err_ev;
  logic [DATA_W-1:0] rd_arr [NUM_SLAVES];

  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_rd
    assign rd_arr[g] = PRDATA_S[g*DATA_W +: DATA_W];
  end

  apb_ic_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_W     (ADDR_W),
    .IDX_W      (IDX_W),
    .SLV_BASE   (SLV_BASE),
    .SLV_MASK   (SLV_MASK)
  ) u_dec (
    .addr (PADDR),
    .idx  (dec_idx),
    .miss (dec_miss)
  );

  // state_q records the phase of the previous cycle, so an access
  // cycle is only honoured when it follows a setup or a wait state.
  assign setup   = PSEL & ~PENABLE;
  assign access  = PSEL & PENABLE & (state_q != ST_IDLE);
  assign slv_rdy = PREADY_S[sel_q];
  assign cur_idx = access ? sel_q : dec_idx;
  assign cur_def = access ? def_q : dec_miss;

`ifdef APB_IC_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign abort = access & ~def_q & ~slv_rdy &
                 (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    cnt_d = cnt_q;
    if (setup) begin
      cnt_d = '0;
    end else if (access & ~def_q & ~slv_rdy & ~abort) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign abort = 1'b0;
`endif

  assign pready_m  = access & (def_q | slv_rdy | abort);
  assign pslverr_m = access &
                     (def_q | abort | (slv_rdy & PSLVERR_S[sel_q]));
  assign err_ev    = pready_m & pslverr_m;

  always_comb begin
    for (int i = 0; i < NUM_SLAVES; i++) begin
      PSEL_S[i] = PSEL & ~cur_def & ~abort & ~PRESET &
                  (cur_idx == IDX_W'(i));
      PENABLE_S[i] = PENABLE & PSEL_S[i];
    end
  end

  assign PWRITE_S = PWRITE;
  assign PADDR_S  = PADDR;
  assign PWDATA_S = PWDATA;

  assign PREADY  = pready_m & ~PRESET;
  assign PSLVERR = pslverr_m & ~PRESET;
  assign PRDATA  = (access & ~def_q & slv_rdy & ~PRESET) ?
                   rd_arr[sel_q] : '0;

  always_comb begin
    state_d = ST_IDLE;
    if (PSEL) begin
      if (!PENABLE) state_d = ST_SETUP;
      else if (access && !pready_m) state_d = ST_ACCESS;
    end
  end

  assign sel_d = setup ? dec_idx : sel_q;
  assign def_d = setup ? dec_miss : def_q;

  // A clear in the same cycle as a new error still captures it.
  always_comb begin
    err_valid_d = err_valid_q;
    err_code_d  = err_code_q;
    err_addr_d  = err_addr_q;
    if (err_clr) err_valid_d = 1'b0;
    if (err_ev && (!err_valid_q || err_clr)) begin
      err_valid_d = 1'b1;
      err_addr_d  = PADDR;
      if (def_q)        err_code_d = ERR_DECODE;
      else if (slv_rdy) err_code_d = ERR_SLVERR;
      else              err_code_d = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      def_q       <= 1'b0;
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      def_q       <= def_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;
  assign err_addr  = err_addr_q;

endmodule
